riscv_multicycle_controller: RTL and testbench

RISCV_MULTICYCLE_CONTROLLER -- requirements
Module: riscv_multicycle_controller

---
 rtl/riscv_multicycle_controller.sv | 194 +++++++++++++++++++
 tb/tb_riscv_multicycle_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32I control FSM: registered state, decoded controls and write enables.
// Optional RV_MC_ILLEGAL_TRAP_EN: illegal opcodes park in HALT and drive the extra halted port.
module riscv_multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] AluOp,
    output logic [2:0] ImmSrc,
    output logic [3:0] state,
    output logic       retire
`ifdef RV_MC_ILLEGAL_TRAP_EN
    ,
    output logic       halted
`endif
);

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    state_t state_q, state_d;
    logic   pc_write_c, ir_write_c, reg_write_c, mem_write_c, retire_c;
    logic   taken_c;

    assign taken_c = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state and per-state control decode
    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        AluOp       = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pc_write_c = mem_ready;
                ir_write_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI:            state_d = S_LUI;
`ifdef RV_MC_ILLEGAL_TRAP_EN
                    default:           state_d = S_HALT;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                AluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                AluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                AluOp      = 2'b01;
                pc_write_c = taken_c;
                state_d    = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JALR2;
            end
            S_LUI: begin
                ResultSrc   = 2'b11;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate format follows the IR opcode in every state
    always_comb begin
        case (opcode)
            OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:                   ImmSrc = 3'b001;
            OP_BRANCH:                  ImmSrc = 3'b010;
            OP_LUI:                     ImmSrc = 3'b011;
            OP_JAL:                     ImmSrc = 3'b100;
            default:                    ImmSrc = 3'b000;
        endcase
    end

    assign retire_c = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_HALT);

    // Write enables are gated by reset so nothing commits while rst_n is low
    assign PCWrite  = pc_write_c  & rst_n;
    assign IRWrite  = ir_write_c  & rst_n;
    assign RegWrite = reg_write_c & rst_n;
    assign MemWrite = mem_write_c & rst_n;
    assign retire   = retire_c    & rst_n;
    assign state    = STATE_W'(state_q);

`ifdef RV_MC_ILLEGAL_TRAP_EN
    assign halted = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Bench for riscv_multicycle_controller: per-instruction expected state traces built from opcode class.
module tb_riscv_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, retire;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, AluOp;
    logic [2:0] ImmSrc;
    logic [3:0] state;
`ifdef RV_MC_ILLEGAL_TRAP_EN
    logic       halted;
`endif

    riscv_multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .AluOp(AluOp), .ImmSrc(ImmSrc), .state(state), .retire(retire)
`ifdef RV_MC_ILLEGAL_TRAP_EN
        , .halted(halted)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int seq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, AluOp} per state number, straight from the control table
    function automatic logic [8:0] exp_sel(input int st);
        case (st)
            0:       return {1'b0, 2'b00, 2'b10, 2'b10, 2'b00};
            1:       return {1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
            2, 11:   return {1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
            3, 5:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
            4:       return {1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
            6:       return {1'b0, 2'b10, 2'b00, 2'b00, 2'b10};
            7:       return {1'b0, 2'b10, 2'b01, 2'b00, 2'b10};
            9:       return {1'b0, 2'b10, 2'b00, 2'b00, 2'b01};
            10, 12:  return {1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
            13:      return {1'b0, 2'b00, 2'b00, 2'b11, 2'b00};
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b0110111: return 3'b011;
            7'b1101111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    // Expected state trace of one instruction: fetch wait, then the opcode's path
    task automatic build(input logic [6:0] op, input int fw, input int mw);
        seq.delete();
        for (int i = 0; i <= fw; i++) seq.push_back(0);
        seq.push_back(1);
        case (op)
            7'b0000011: begin seq.push_back(2); for (int i = 0; i <= mw; i++) seq.push_back(3); seq.push_back(4); end
            7'b0100011: begin seq.push_back(2); for (int i = 0; i <= mw; i++) seq.push_back(5); end
            7'b0110011: begin seq.push_back(6); seq.push_back(8); end
            7'b0010011: begin seq.push_back(7); seq.push_back(8); end
            7'b1100011: seq.push_back(9);
            7'b1101111: begin seq.push_back(10); seq.push_back(8); end
            7'b1100111: begin seq.push_back(11); seq.push_back(12); seq.push_back(8); end
            7'b0110111: seq.push_back(13);
            default: ;
        endcase
    endtask

    // Drive and check the trace in seq; entered and left on a falling edge
    task automatic run_seq(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int fw, input int mw, input bit ret_last);
        int  fcnt = 0;
        int  mcnt = 0;
        bit  taken;
        taken  = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
        opcode = op;
        funct3 = f3;
        zero   = z;
        for (int i = 0; i < seq.size(); i++) begin
            int         st;
            logic       mr;
            logic       pcw;
            logic [4:0] wen;
            st = seq[i];
            if (st == 0) begin
                mr = (fcnt == fw);
                fcnt++;
            end else if (st == 3 || st == 5) begin
                mr = (mcnt == mw);
                mcnt++;
            end else begin
                mr = 1'($urandom % 2);
            end
            mem_ready = mr;
            #1;
            pcw = (st == 0) ? mr : (st == 9) ? taken : (st == 10 || st == 12);
            wen = {pcw, (st == 0) && mr, (st == 4 || st == 8 || st == 13), st == 5,
                   ret_last && (i == seq.size() - 1)};
            check("state", 32'(state), 32'(st));
            check("sel", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, AluOp}), 32'(exp_sel(st)));
            check("wen", 32'({PCWrite, IRWrite, RegWrite, MemWrite, retire}), 32'(wen));
            check("imm", 32'(ImmSrc), 32'(exp_imm(op)));
`ifdef RV_MC_ILLEGAL_TRAP_EN
            check("halted", 32'(halted), 32'(st == 14));
`endif
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fw, input int mw);
        build(op, fw, mw);
        run_seq(op, f3, z, fw, mw, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_wen"}, 32'({PCWrite, IRWrite, RegWrite, MemWrite, retire}), 32'd0);
    endtask

    logic [6:0] ops[10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111, 7'b0000000};

    initial begin
        // Reset holds FETCH with writes suppressed even while mem_ready is high
        mem_ready = 1'b1;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        check_reset_outputs("por_edge");
        rst_n = 1'b1;

        run_instr(7'b0000011, 3'd2, 1'b0, 0, 3);
        run_instr(7'b1100011, 3'd0, 1'b1, 0, 0);
        run_instr(7'b1100011, 3'd0, 1'b0, 1, 0);
        run_instr(7'b1100011, 3'd1, 1'b1, 0, 0);
        run_instr(7'b1100011, 3'd1, 1'b0, 0, 0);
        run_instr(7'b1100111, 3'd0, 1'b0, 0, 0);
        run_instr(7'b0100011, 3'd2, 1'b0, 0, 0);

        // Reset in the middle of a store that is waiting on memory
        build(7'b0100011, 0, 3);
        void'(seq.pop_back());
        void'(seq.pop_back());
        run_seq(7'b0100011, 3'd2, 1'b0, 0, 3, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("pre_rst_state", 32'(state), 32'd5);
        check("pre_rst_memwrite", 32'(MemWrite), 32'd1);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        check_reset_outputs("mid_rst_edge");
        rst_n = 1'b1;

`ifdef RV_MC_ILLEGAL_TRAP_EN
        seq = '{0, 1, 14, 14, 14, 14};
        run_seq(7'b1111111, 3'd0, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("halt_rst");
        check("halt_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        run_instr(7'b1111111, 3'd0, 1'b0, 0, 0);
`endif

        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
`ifdef RV_MC_ILLEGAL_TRAP_EN
            op = ops[$urandom % 8];
`else
            op = ops[$urandom % 10];
`endif
            run_instr(op, 3'($urandom % 8), 1'($urandom % 2), int'($urandom % 3), int'($urandom % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
